// File: rtl/cpu7_excp_ctl_pkg.sv
// Shared constants and types for the exception/ERTN sequencer.
package cpu7_excp_ctl_pkg;

  localparam int unsigned EXCCODE_W = 6;
  localparam int unsigned CNT_W     = 4;

  localparam logic [EXCCODE_W-1:0] EXCCODE_INT  = 6'h00;
  localparam logic [EXCCODE_W-1:0] EXCCODE_ADEF = 6'h08;
  localparam logic [EXCCODE_W-1:0] EXCCODE_ALE  = 6'h09;
  localparam logic [EXCCODE_W-1:0] EXCCODE_SYS  = 6'h0B;
  localparam logic [EXCCODE_W-1:0] EXCCODE_BRK  = 6'h0C;
  localparam logic [EXCCODE_W-1:0] EXCCODE_INE  = 6'h0D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_DRAIN = 2'd2
  } excp_state_e;

endpackage

// File: rtl/cpu7_excp_prio.sv
// Fixed-priority encoder over the exception/interrupt sources.
module cpu7_excp_prio
  import cpu7_excp_ctl_pkg::*;
(
  input  logic                 intr,
  input  logic                 adef,
  input  logic                 ine,
  input  logic                 sys,
  input  logic                 brk,
  input  logic                 ale,
  output logic                 take_except_c,
  output logic [EXCCODE_W-1:0] exccode_c
);

  // Highest-priority active source selects the exccode.
  always_comb begin
    take_except_c = 1'b0;
    exccode_c     = EXCCODE_INT;
    if (intr) begin
      take_except_c = 1'b1;
      exccode_c     = EXCCODE_INT;
    end else if (adef) begin
      take_except_c = 1'b1;
      exccode_c     = EXCCODE_ADEF;
    end else if (ine) begin
      take_except_c = 1'b1;
      exccode_c     = EXCCODE_INE;
    end else if (sys) begin
      take_except_c = 1'b1;
      exccode_c     = EXCCODE_SYS;
    end else if (brk) begin
      take_except_c = 1'b1;
      exccode_c     = EXCCODE_BRK;
    end else if (ale) begin
      take_except_c = 1'b1;
      exccode_c     = EXCCODE_ALE;
    end
  end

endmodule

// File: rtl/cpu7_excp_ctl.sv
// Exception/ERTN sequencer: commit strobes to CSR, held redirect to IFU,
// pipeline flush/stall until the redirect is acknowledged and drained.
module cpu7_excp_ctl
  import cpu7_excp_ctl_pkg::*;
#(
  parameter int unsigned GRLEN        = 32,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 valid_e,
  input  logic [GRLEN-1:0]     pc_e,
  input  logic                 adef_e,
  input  logic                 ine_e,
  input  logic                 sys_e,
  input  logic                 brk_e,
  input  logic                 ale_e,
  input  logic                 ertn_e,
  input  logic                 csr_ecl_timer_intr,
  input  logic [GRLEN-1:0]     csr_eentry,
  input  logic [GRLEN-1:0]     csr_era,
  input  logic                 ifu_ecl_redirect_ack,
  output logic                 exu_ifu_except,
  output logic [EXCCODE_W-1:0] ecl_csr_exccode_e,
  output logic                 ecl_csr_ertn_e,
  output logic                 ecl_ifu_redirect_valid,
  output logic [GRLEN-1:0]     ecl_ifu_redirect_pc,
  output logic                 ecl_pipe_flush,
  output logic                 ecl_pipe_stall
);

  excp_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 redir_valid_q, redir_valid_d;
  logic [GRLEN-1:0]     redir_pc_q, redir_pc_d;

  logic                 take_except;
  logic [EXCCODE_W-1:0] exccode;
  logic                 accept;
  logic                 except_c;
  logic                 ertn_c;

  // The CSR captures ERA from pc_e itself; it is only carried on this port.
  logic unused_pc_e;
  assign unused_pc_e = ^pc_e;

  cpu7_excp_prio u_prio (
    .intr          (csr_ecl_timer_intr),
    .adef          (adef_e),
    .ine           (ine_e),
    .sys           (sys_e),
    .brk           (brk_e),
    .ale           (ale_e),
    .take_except_c (take_except),
    .exccode_c     (exccode)
  );

  // Events are only taken from a live _e instruction while IDLE.
  always_comb begin
    accept   = (state_q == ST_IDLE) && valid_e && resetn;
    except_c = accept && take_except;
    ertn_c   = accept && ertn_e && !take_except;
  end

  // Same-cycle commit strobes and pipeline control.
  always_comb begin
    exu_ifu_except         = except_c;
    ecl_csr_exccode_e      = except_c ? exccode : EXCCODE_W'(0);
    ecl_csr_ertn_e         = ertn_c;
    ecl_pipe_flush         = except_c || ertn_c || (state_q != ST_IDLE);
    ecl_pipe_stall         = (state_q != ST_IDLE);
    ecl_ifu_redirect_valid = redir_valid_q;
    ecl_ifu_redirect_pc    = redir_pc_q;
  end

  // Next-state, redirect target and drain counter.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (except_c || ertn_c) begin
          state_d       = ST_REDIR;
          redir_valid_d = 1'b1;
          redir_pc_d    = except_c ? csr_eentry : csr_era;
        end
      end
      ST_REDIR: begin
        if (ifu_ecl_redirect_ack) begin
          state_d       = ST_DRAIN;
          redir_valid_d = 1'b0;
          redir_pc_d    = GRLEN'(0);
          cnt_d         = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(0)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d       = ST_IDLE;
        cnt_d         = CNT_W'(0);
        redir_valid_d = 1'b0;
        redir_pc_d    = GRLEN'(0);
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_W'(0);
      redir_valid_q <= 1'b0;
      redir_pc_q    <= GRLEN'(0);
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

endmodule

// File: tb/tb_cpu7_excp_ctl.sv
// Directed self-checking bench for cpu7_excp_ctl.
module tb_cpu7_excp_ctl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_e;
  logic [31:0] pc_e;
  logic        adef_e, ine_e, sys_e, brk_e, ale_e, ertn_e;
  logic        csr_ecl_timer_intr;
  logic [31:0] csr_eentry, csr_era;
  logic        ifu_ecl_redirect_ack;
  logic        exu_ifu_except;
  logic [5:0]  ecl_csr_exccode_e;
  logic        ecl_csr_ertn_e;
  logic        ecl_ifu_redirect_valid;
  logic [31:0] ecl_ifu_redirect_pc;
  logic        ecl_pipe_flush;
  logic        ecl_pipe_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu7_excp_ctl #(.GRLEN(32), .DRAIN_CYCLES(2)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .valid_e                (valid_e),
    .pc_e                   (pc_e),
    .adef_e                 (adef_e),
    .ine_e                  (ine_e),
    .sys_e                  (sys_e),
    .brk_e                  (brk_e),
    .ale_e                  (ale_e),
    .ertn_e                 (ertn_e),
    .csr_ecl_timer_intr     (csr_ecl_timer_intr),
    .csr_eentry             (csr_eentry),
    .csr_era                (csr_era),
    .ifu_ecl_redirect_ack   (ifu_ecl_redirect_ack),
    .exu_ifu_except         (exu_ifu_except),
    .ecl_csr_exccode_e      (ecl_csr_exccode_e),
    .ecl_csr_ertn_e         (ecl_csr_ertn_e),
    .ecl_ifu_redirect_valid (ecl_ifu_redirect_valid),
    .ecl_ifu_redirect_pc    (ecl_ifu_redirect_pc),
    .ecl_pipe_flush         (ecl_pipe_flush),
    .ecl_pipe_stall         (ecl_pipe_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_srcs();
    valid_e = 1'b0; adef_e = 1'b0; ine_e = 1'b0; sys_e = 1'b0;
    brk_e = 1'b0; ale_e = 1'b0; ertn_e = 1'b0; csr_ecl_timer_intr = 1'b0;
    ifu_ecl_redirect_ack = 1'b0;
  endtask

  // Wait for the redirect, acknowledge it, then wait for the pipe to drain.
  task automatic finish_redirect();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ecl_ifu_redirect_valid === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL finish_redirect: redirect_valid never seen, got %b want 1", ecl_ifu_redirect_valid);
    end
    ifu_ecl_redirect_ack = 1'b1;
    tick();
    ifu_ecl_redirect_ack = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (ecl_pipe_stall === 1'b0) got = 1'b1;
      else tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL finish_redirect: stall stuck, got %b want 0", ecl_pipe_stall);
    end
  endtask

  task automatic test_reset();
    clear_srcs();
    resetn = 1'b0;
    pc_e = 32'h0; csr_eentry = 32'h1c008000; csr_era = 32'h1c000240;
    tick(); tick();
    checks++;
    if ({exu_ifu_except, ecl_csr_ertn_e, ecl_ifu_redirect_valid, ecl_pipe_flush, ecl_pipe_stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 00000",
               {exu_ifu_except, ecl_csr_ertn_e, ecl_ifu_redirect_valid, ecl_pipe_flush, ecl_pipe_stall});
    end
    checks++;
    if (ecl_ifu_redirect_pc !== 32'h0 || ecl_csr_exccode_e !== 6'h0) begin
      errors++;
      $display("FAIL reset_pc_code: got pc %h code %h want 0/0", ecl_ifu_redirect_pc, ecl_csr_exccode_e);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_redir();
    valid_e = 1'b1; ale_e = 1'b1; pc_e = 32'h1c000100;
    #1;
    checks++;
    if (exu_ifu_except !== 1'b1 || ecl_csr_exccode_e !== 6'h09) begin
      errors++;
      $display("FAIL rst_redir_event: got except %b code %h want 1/09", exu_ifu_except, ecl_csr_exccode_e);
    end
    tick();
    clear_srcs();
    #1;
    checks++;
    if (ecl_ifu_redirect_valid !== 1'b1 || ecl_pipe_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_redir_inredir: got rv %b stall %b want 1/1", ecl_ifu_redirect_valid, ecl_pipe_stall);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if ({exu_ifu_except, ecl_csr_ertn_e, ecl_ifu_redirect_valid, ecl_pipe_flush, ecl_pipe_stall} !== 5'b0
        || ecl_ifu_redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_redir_abort: got flags %b pc %h want 00000/0",
               {exu_ifu_except, ecl_csr_ertn_e, ecl_ifu_redirect_valid, ecl_pipe_flush, ecl_pipe_stall},
               ecl_ifu_redirect_pc);
    end
    valid_e = 1'b1; sys_e = 1'b1;
    #1;
    checks++;
    if (exu_ifu_except !== 1'b1 || ecl_csr_exccode_e !== 6'h0B) begin
      errors++;
      $display("FAIL rst_redir_fresh: got except %b code %h want 1/0b", exu_ifu_except, ecl_csr_exccode_e);
    end
    tick();
    clear_srcs();
    finish_redirect();
  endtask

  task automatic test_ale_redirect();
    int rv_cycles;
    csr_eentry = 32'h1c008000;
    valid_e = 1'b1; ale_e = 1'b1; pc_e = 32'h1c000104;
    #1;
    checks++;
    if (exu_ifu_except !== 1'b1 || ecl_csr_exccode_e !== 6'h09 || ecl_csr_ertn_e !== 1'b0
        || ecl_pipe_flush !== 1'b1 || ecl_pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL ale_event: got exc %b code %h ertn %b flush %b stall %b want 1/09/0/1/0",
               exu_ifu_except, ecl_csr_exccode_e, ecl_csr_ertn_e, ecl_pipe_flush, ecl_pipe_stall);
    end
    tick();
    clear_srcs();
    rv_cycles = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) ifu_ecl_redirect_ack = 1'b1;
      #1;
      checks++;
      if (ecl_ifu_redirect_valid !== 1'b1 || ecl_ifu_redirect_pc !== 32'h1c008000
          || exu_ifu_except !== 1'b0 || ecl_pipe_flush !== 1'b1 || ecl_pipe_stall !== 1'b1) begin
        errors++;
        $display("FAIL ale_redir_c%0d: got rv %b pc %h exc %b flush %b stall %b want 1/1c008000/0/1/1",
                 c, ecl_ifu_redirect_valid, ecl_ifu_redirect_pc, exu_ifu_except, ecl_pipe_flush, ecl_pipe_stall);
      end
      if (ecl_ifu_redirect_valid === 1'b1) rv_cycles++;
      tick();
    end
    ifu_ecl_redirect_ack = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++;
      if (ecl_ifu_redirect_valid !== 1'b0 || ecl_pipe_flush !== 1'b1 || ecl_pipe_stall !== 1'b1) begin
        errors++;
        $display("FAIL ale_drain_c%0d: got rv %b flush %b stall %b want 0/1/1",
                 c, ecl_ifu_redirect_valid, ecl_pipe_flush, ecl_pipe_stall);
      end
      tick();
    end
    checks++;
    if (ecl_pipe_flush !== 1'b0 || ecl_pipe_stall !== 1'b0 || ecl_ifu_redirect_pc !== 32'h0 || rv_cycles != 3) begin
      errors++;
      $display("FAIL ale_idle: got flush %b stall %b pc %h rv_cycles %0d want 0/0/0/3",
               ecl_pipe_flush, ecl_pipe_stall, ecl_ifu_redirect_pc, rv_cycles);
    end
  endtask

  task automatic test_priority();
    valid_e = 1'b0; csr_ecl_timer_intr = 1'b1;
    #1;
    checks++;
    if (exu_ifu_except !== 1'b0 || ecl_pipe_flush !== 1'b0) begin
      errors++;
      $display("FAIL prio_intr_deferred: got exc %b flush %b want 0/0", exu_ifu_except, ecl_pipe_flush);
    end
    valid_e = 1'b1; ine_e = 1'b1; sys_e = 1'b1;
    #1;
    checks++;
    if (exu_ifu_except !== 1'b1 || ecl_csr_exccode_e !== 6'h00) begin
      errors++;
      $display("FAIL prio_intr: got exc %b code %h want 1/00", exu_ifu_except, ecl_csr_exccode_e);
    end
    csr_ecl_timer_intr = 1'b0;
    #1;
    checks++;
    if (exu_ifu_except !== 1'b1 || ecl_csr_exccode_e !== 6'h0D) begin
      errors++;
      $display("FAIL prio_ine: got exc %b code %h want 1/0d", exu_ifu_except, ecl_csr_exccode_e);
    end
    ine_e = 1'b0; brk_e = 1'b1;
    #1;
    checks++;
    if (exu_ifu_except !== 1'b1 || ecl_csr_exccode_e !== 6'h0B) begin
      errors++;
      $display("FAIL prio_sys: got exc %b code %h want 1/0b", exu_ifu_except, ecl_csr_exccode_e);
    end
    sys_e = 1'b0; adef_e = 1'b1; ale_e = 1'b1;
    #1;
    checks++;
    if (exu_ifu_except !== 1'b1 || ecl_csr_exccode_e !== 6'h08) begin
      errors++;
      $display("FAIL prio_adef: got exc %b code %h want 1/08", exu_ifu_except, ecl_csr_exccode_e);
    end
    clear_srcs();
    tick();
    checks++;
    if (ecl_pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL prio_no_event: got stall %b want 0", ecl_pipe_stall);
    end
  endtask

  task automatic test_ertn();
    csr_era = 32'h1c000240;
    valid_e = 1'b1; ertn_e = 1'b1;
    #1;
    checks++;
    if (ecl_csr_ertn_e !== 1'b1 || exu_ifu_except !== 1'b0 || ecl_pipe_flush !== 1'b1) begin
      errors++;
      $display("FAIL ertn_event: got ertn %b exc %b flush %b want 1/0/1", ecl_csr_ertn_e, exu_ifu_except, ecl_pipe_flush);
    end
    tick();
    clear_srcs();
    ifu_ecl_redirect_ack = 1'b1;
    #1;
    checks++;
    if (ecl_ifu_redirect_valid !== 1'b1 || ecl_ifu_redirect_pc !== 32'h1c000240 || ecl_csr_ertn_e !== 1'b0) begin
      errors++;
      $display("FAIL ertn_redir: got rv %b pc %h ertn %b want 1/1c000240/0",
               ecl_ifu_redirect_valid, ecl_ifu_redirect_pc, ecl_csr_ertn_e);
    end
    tick();
    ifu_ecl_redirect_ack = 1'b0;
    checks++;
    if (ecl_ifu_redirect_valid !== 1'b0 || ecl_pipe_stall !== 1'b1) begin
      errors++;
      $display("FAIL ertn_drain1: got rv %b stall %b want 0/1", ecl_ifu_redirect_valid, ecl_pipe_stall);
    end
    tick();
    checks++;
    if (ecl_pipe_stall !== 1'b1) begin
      errors++;
      $display("FAIL ertn_drain2: got stall %b want 1", ecl_pipe_stall);
    end
    tick();
    checks++;
    if (ecl_pipe_stall !== 1'b0 || ecl_pipe_flush !== 1'b0) begin
      errors++;
      $display("FAIL ertn_idle: got stall %b flush %b want 0/0", ecl_pipe_stall, ecl_pipe_flush);
    end
  endtask

  task automatic test_ertn_brk();
    csr_eentry = 32'h1c00c000; csr_era = 32'h1c000300;
    valid_e = 1'b1; ertn_e = 1'b1; brk_e = 1'b1;
    #1;
    checks++;
    if (exu_ifu_except !== 1'b1 || ecl_csr_exccode_e !== 6'h0C || ecl_csr_ertn_e !== 1'b0) begin
      errors++;
      $display("FAIL ertn_brk_event: got exc %b code %h ertn %b want 1/0c/0",
               exu_ifu_except, ecl_csr_exccode_e, ecl_csr_ertn_e);
    end
    tick();
    clear_srcs();
    #1;
    checks++;
    if (ecl_ifu_redirect_pc !== 32'h1c00c000) begin
      errors++;
      $display("FAIL ertn_brk_target: got %h want 1c00c000", ecl_ifu_redirect_pc);
    end
    finish_redirect();
  endtask

  task automatic test_back_to_back();
    csr_eentry = 32'h1c008000;
    valid_e = 1'b1; sys_e = 1'b1;
    #1;
    checks++;
    if (exu_ifu_except !== 1'b1 || ecl_csr_exccode_e !== 6'h0B) begin
      errors++;
      $display("FAIL b2b_first: got exc %b code %h want 1/0b", exu_ifu_except, ecl_csr_exccode_e);
    end
    tick();
    for (int c = 1; c <= 4; c++) begin
      ertn_e = (c % 2 == 0);
      ifu_ecl_redirect_ack = (c == 2);
      #1;
      checks++;
      if (exu_ifu_except !== 1'b0 || ecl_csr_ertn_e !== 1'b0 || ecl_pipe_stall !== 1'b1) begin
        errors++;
        $display("FAIL b2b_busy_c%0d: got exc %b ertn %b stall %b want 0/0/1",
                 c, exu_ifu_except, ecl_csr_ertn_e, ecl_pipe_stall);
      end
      tick();
    end
    ertn_e = 1'b0;
    ifu_ecl_redirect_ack = 1'b0;
    #1;
    checks++;
    if (exu_ifu_except !== 1'b1 || ecl_csr_exccode_e !== 6'h0B || ecl_pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reaccept: got exc %b code %h stall %b want 1/0b/0",
               exu_ifu_except, ecl_csr_exccode_e, ecl_pipe_stall);
    end
    tick();
    clear_srcs();
    finish_redirect();
  endtask

  initial begin
    test_reset();
    test_reset_mid_redir();
    test_ale_redirect();
    test_priority();
    test_ertn();
    test_ertn_brk();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
